// File: rtl/bnn_infer_ctrl.sv
// bnn_infer_ctrl: hands one buffered image to a BNN core, waits for the
// core's class index under a watchdog, and holds the result until the
// consumer acknowledges it.
module bnn_infer_ctrl #(
  parameter int unsigned IMG_DIM     = 30,
  parameter int unsigned NUM_CH      = 1,
  parameter int unsigned PAD_BITS    = 4,
  parameter int unsigned RES_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 4096,
  localparam int unsigned PIX        = NUM_CH * IMG_DIM * IMG_DIM,
  localparam int unsigned IN_W       = PIX + PAD_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  img_in,
  input  logic             img_valid,
  output logic             img_ready,
  output logic [PIX-1:0]   core_img,
  output logic             core_start,
  input  logic             core_done,
  input  logic [RES_W-1:0] core_result,
  output logic [RES_W-1:0] result_out,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             busy,
  output logic             timeout_err,
  output logic [15:0]      infer_cnt
);

  localparam int unsigned WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit          TO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             r_state;
  logic [PIX-1:0]     r_core_img;
  logic               r_core_start;
  logic [RES_W-1:0]   r_result_out;
  logic               r_result_valid;
  logic [15:0]        r_infer_cnt;
  logic               r_timeout_err;
  logic [WD_W-1:0]    r_wd;

  state_t             w_state_nxt;
  logic [PIX-1:0]     w_core_img_nxt;
  logic               w_core_start_nxt;
  logic [RES_W-1:0]   w_result_out_nxt;
  logic               w_result_valid_nxt;
  logic [15:0]        w_infer_cnt_nxt;
  logic               w_timeout_err_nxt;
  logic [WD_W-1:0]    w_wd_nxt;
  logic               w_wd_expired;

  // Watchdog has reached its last allowed WAIT cycle.
  assign w_wd_expired = TO_EN && (r_wd == WD_W'(TIMEOUT_CYC - 1));

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_core_img     <= '0;
      r_core_start   <= 1'b0;
      r_result_out   <= '0;
      r_result_valid <= 1'b0;
      r_infer_cnt    <= '0;
      r_timeout_err  <= 1'b0;
      r_wd           <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_core_img     <= w_core_img_nxt;
      r_core_start   <= w_core_start_nxt;
      r_result_out   <= w_result_out_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_infer_cnt    <= w_infer_cnt_nxt;
      r_timeout_err  <= w_timeout_err_nxt;
      r_wd           <= w_wd_nxt;
    end
  end

  // Next-state and next-output decode; core_done only matters in WAIT,
  // and it takes priority over a coincident watchdog expiry.
  always_comb begin
    w_state_nxt        = r_state;
    w_core_img_nxt     = r_core_img;
    w_core_start_nxt   = 1'b0;
    w_result_out_nxt   = r_result_out;
    w_result_valid_nxt = r_result_valid;
    w_infer_cnt_nxt    = r_infer_cnt;
    w_timeout_err_nxt  = r_timeout_err;
    w_wd_nxt           = r_wd;
    case (r_state)
      IDLE: begin
        if (img_valid) begin
          w_core_img_nxt = img_in[IN_W-1:PAD_BITS];
          w_state_nxt    = START;
        end
      end
      START: begin
        w_core_start_nxt = 1'b1;
        w_wd_nxt         = '0;
        w_state_nxt      = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          w_result_out_nxt   = core_result;
          w_result_valid_nxt = 1'b1;
          w_infer_cnt_nxt    = 16'(r_infer_cnt + 16'd1);
          w_timeout_err_nxt  = 1'b0;
          w_state_nxt        = HOLD;
        end else if (w_wd_expired) begin
          w_result_out_nxt   = '1;
          w_result_valid_nxt = 1'b1;
          w_timeout_err_nxt  = 1'b1;
          w_state_nxt        = HOLD;
        end else begin
          w_wd_nxt = WD_W'(r_wd + 1'b1);
        end
      end
      HOLD: begin
        if (result_ack) begin
          w_result_valid_nxt = 1'b0;
          w_state_nxt        = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign img_ready    = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign core_img     = r_core_img;
  assign core_start   = r_core_start;
  assign result_out   = r_result_out;
  assign result_valid = r_result_valid;
  assign timeout_err  = r_timeout_err;
  assign infer_cnt    = r_infer_cnt;

endmodule

// File: doc/bnn_infer_ctrl.md
BNN_INFER_CTRL -- requirements
Module: bnn_infer_ctrl

Interface
REQ-001 Parameter IMG_DIM, default 30, image side length in pixels.
REQ-002 Parameter NUM_CH, default 1, input channel count.
REQ-003 Parameter PAD_BITS, default 4, LSB pad bits on img_in, discarded.
REQ-004 Parameter RES_W, default 4, class-index width.
REQ-005 Parameter TIMEOUT_CYC, default 4096, maximum WAIT cycles; 0 disables the timeout.
REQ-006 Derived constant PIX = NUM_CH*IMG_DIM*IMG_DIM; IN_W = PIX+PAD_BITS.
REQ-007 clk  input  1  clock; all flops rise-edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 img_in  input  IN_W  packed image from the buffer, channel 0 in the MSBs.
REQ-010 img_valid  input  1  buffer full; image on img_in valid.
REQ-011 img_ready  output  1  controller accepts an image this cycle.
REQ-012 core_img  output  PIX  latched image to the core, equal to img_in[IN_W-1:PAD_BITS].
REQ-013 core_start  output  1  single-cycle start pulse to the core.
REQ-014 core_done  input  1  core result valid, one or more cycles.
REQ-015 core_result  input  RES_W  core class index.
REQ-016 result_out  output  RES_W  held result.
REQ-017 result_valid  output  1  result_out valid; held until acknowledged.
REQ-018 result_ack  input  1  consumer accepts the result.
REQ-019 busy  output  1  high in any state except IDLE.
REQ-020 timeout_err  output  1  sticky timeout flag.
REQ-021 infer_cnt  output  16  completed-inference count.

Function
REQ-022 FSM states: IDLE, START, WAIT, HOLD.
REQ-023 img_ready is high only in IDLE; img_ready is a combinational output of the state register.
REQ-024 In IDLE with img_valid high, the controller latches img_in[IN_W-1:PAD_BITS] into core_img and moves to START.
REQ-025 In START, core_start is 1 for exactly one cycle; the FSM then moves to WAIT and clears the watchdog counter.
REQ-026 core_done is ignored in every state except WAIT.
REQ-027 In WAIT with core_done high, the controller captures core_result into result_out, sets result_valid, increments infer_cnt (wraps at 0xFFFF to 0), and moves to HOLD.
REQ-028 Latency: core_start asserts 2 cycles after the img_valid acceptance edge; result_valid asserts 1 cycle after the core_done sample.
REQ-029 In WAIT without core_done, the watchdog increments each cycle.
REQ-030 When TIMEOUT_CYC is nonzero and the watchdog reaches TIMEOUT_CYC-1 without core_done, the controller sets timeout_err, sets result_valid, sets result_out to all ones, leaves infer_cnt unchanged, and moves to HOLD.
REQ-031 If core_done and the timeout occur in the same cycle, core_done wins: the normal completion path is taken and timeout_err is not set.
REQ-032 In HOLD, result_out and result_valid stay stable until result_ack is high; on that edge result_valid clears and the FSM returns to IDLE.
REQ-033 result_ack is ignored while result_valid is low.
REQ-034 A back-to-back image can be accepted on the cycle after the ack, so the minimum cycle is 4 clocks per image plus core latency.
REQ-035 core_img holds its value between acceptances; img_in changes after acceptance do not affect core_img.
REQ-036 timeout_err clears only on reset or on the next successful core_done completion.

Reset
REQ-037 On rst_n low, asynchronously: state=IDLE, core_start=0, result_valid=0, result_out=0, core_img=0, infer_cnt=0, timeout_err=0, watchdog=0.
REQ-038 Reset mid-inference abandons the current job; a core_done arriving after reset release while the FSM is in IDLE is ignored.
REQ-039 Reset deassertion is synchronised to clk by the system; the block takes no action on the first post-reset edge other than sampling img_valid.

Verification
REQ-040 Nominal: NUM_CH=1, img_in LSB nibble=0xF, img_valid, core_done 10 cycles after core_start with result 7 -> core_img excludes the nibble; core_start is one pulse; result_out=7; result_valid holds until ack; infer_cnt=1.
REQ-041 Timeout: TIMEOUT_CYC=16, no core_done -> at WAIT cycle 16 timeout_err=1, result_out=0xF, infer_cnt unchanged; after ack the FSM is in IDLE.
REQ-042 Race: core_done in the same cycle as the timeout -> normal result is captured; timeout_err=0.
REQ-043 Back-pressure: result_ack withheld for 50 cycles while img_valid stays high -> img_ready=0 throughout, no second core_start; after ack the next image is accepted.
REQ-044 Reset in WAIT, then core_done pulse -> no result_valid, infer_cnt=0, all outputs at reset values.
REQ-045 Parameter sweep: NUM_CH=2, IMG_DIM=8, PAD_BITS=0 -> core_img equals img_in bit-exact over 100 random images; infer_cnt=100.
